xeng_vacc: RTL and testbench



---
 rtl/xeng_vacc_if.sv | 34 +++
 rtl/xeng_vacc.sv | 242 ++++++++++++++++++++++++
 tb/tb_xeng_vacc.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/xeng_vacc_if.sv
// ---------------------------------------------------------------------------
// xeng_vacc_if -- bus bundle between the X-engine output and the vector
// accumulator.
//   master : drives sync_in, din, vld, mcnt, acc_len; observes the dump side
//   slave  : the accumulator; consumes X-engine beats and produces
//            dout / vld_out / sync_out / mcnt_out / err
// ---------------------------------------------------------------------------
interface xeng_vacc_if #(
    parameter int IN_WIDTH     = 18,
    parameter int OUT_WIDTH    = 32,
    parameter int ACC_LEN_BITS = 16,
    parameter int MCNT_WIDTH   = 48
);
    logic                    sync_in;
    logic [8*IN_WIDTH-1:0]   din;
    logic                    vld;
    logic [MCNT_WIDTH-1:0]   mcnt;
    logic [ACC_LEN_BITS-1:0] acc_len;
    logic [8*OUT_WIDTH-1:0]  dout;
    logic                    vld_out;
    logic                    sync_out;
    logic [MCNT_WIDTH-1:0]   mcnt_out;
    logic                    err;

    modport master (
        output sync_in, din, vld, mcnt, acc_len,
        input  dout, vld_out, sync_out, mcnt_out, err
    );

    modport slave (
        input  sync_in, din, vld, mcnt, acc_len,
        output dout, vld_out, sync_out, mcnt_out, err
    );
endinterface

// File: rtl/xeng_vacc.sv
// ---------------------------------------------------------------------------
// xeng_vacc -- X-engine vector accumulator.
// Sums acc_len consecutive correlation windows (N_BL baselines each, one
// baseline of 8 signed components per vld beat) and streams the finished
// sums out during the last window of each dump, 2 cycles behind the input.
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   bus     : xeng_vacc_if.slave
//             in : sync_in, din {xx_r,xx_i,xy_r,xy_i,yx_r,yx_i,yy_r,yy_i},
//                  vld, mcnt, acc_len (0 behaves as 1)
//             out: dout (same component order), vld_out, sync_out
//                  (baseline 0 of a dump), mcnt_out (mcnt of the dump's
//                  first beat), err (sticky short-window flag)
// Pipeline: edge 0 samples the beat and reads the stored sum; edge 1 adds,
// writes the RAM back and registers dout.
// ---------------------------------------------------------------------------

// One component lane: window 0 loads the sign-extended input, later
// windows add it to the stored sum (modulo 2^OUT_WIDTH).
module xeng_vacc_lane #(
    parameter int IN_WIDTH  = 18,
    parameter int OUT_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  din_c,
    input  logic [OUT_WIDTH-1:0] acc_c,
    input  logic                 first,
    output logic [OUT_WIDTH-1:0] sum_c
);
    logic [OUT_WIDTH-1:0] ext;

    always_comb begin
        ext   = OUT_WIDTH'($signed(din_c));
        sum_c = first ? ext : acc_c + ext;
    end
endmodule

module xeng_vacc #(
    parameter int N_ANTS       = 8,
    parameter int IN_WIDTH     = 18,
    parameter int OUT_WIDTH    = 32,
    parameter int ACC_LEN_BITS = 16,
    parameter int MCNT_WIDTH   = 48
) (
    input  logic       clk,
    input  logic       rst,
    xeng_vacc_if.slave bus
);
    localparam int N_BL   = N_ANTS * (N_ANTS + 1) / 2;
    localparam int BL_W   = (N_BL > 1) ? $clog2(N_BL) : 1;
    localparam int N_COMP = 8;
    localparam int STAGES = 2;

    typedef enum logic {S_IDLE, S_ACC} state_t;
    typedef logic [N_COMP-1:0][IN_WIDTH-1:0]  vec_in_t;
    typedef logic [N_COMP-1:0][OUT_WIDTH-1:0] vec_out_t;

    // control state
    state_t                  state_q, state_d;
    logic [BL_W-1:0]         bl_cnt_q, bl_cnt_d;
    logic [ACC_LEN_BITS-1:0] win_cnt_q, win_cnt_d;
    logic [ACC_LEN_BITS-1:0] len_q, len_d;
    logic                    err_q, err_d;
    logic [MCNT_WIDTH-1:0]   mcnt_dump_q, mcnt_dump_d;

    // stage 1: sampled beat
    vec_in_t                 s1_din_q, s1_din_d;
    logic [BL_W-1:0]         s1_addr_q, s1_addr_d;
    logic                    s1_first_q, s1_first_d;
    logic                    s1_last_q, s1_last_d;
    logic                    s1_sof_q, s1_sof_d;
    logic [MCNT_WIDTH-1:0]   s1_mcnt_q, s1_mcnt_d;

    // [1] = stage 1 holds a beat, [2] = dout holds an output beat
    logic [STAGES:1]         vld_pipe_q, vld_pipe_d;

    // output stage
    vec_out_t                dout_q, dout_d;
    logic                    sync_out_q, sync_out_d;
    logic [MCNT_WIDTH-1:0]   mcnt_out_q, mcnt_out_d;

    // sum RAM with registered read port
    vec_out_t                mem [N_BL];
    vec_out_t                rd_q, rd_d;
    vec_out_t                sum;

    // per-beat decode
    logic [BL_W-1:0]         bl_base;
    logic [ACC_LEN_BITS-1:0] win_base, len_base, eff_len;
    logic                    beat, kill, b_first, b_last;

    assign eff_len = (bus.acc_len == '0) ? ACC_LEN_BITS'(1) : bus.acc_len;

    // Counters. sync_in rebases the counters before the current beat is
    // decoded, so a coincident vld beat is baseline 0 of window 0.
    always_comb begin
        state_d     = state_q;
        bl_cnt_d    = bl_cnt_q;
        win_cnt_d   = win_cnt_q;
        len_d       = len_q;
        err_d       = err_q;
        mcnt_dump_d = mcnt_dump_q;
        bl_base     = bl_cnt_q;
        win_base    = win_cnt_q;
        len_base    = len_q;
        kill        = 1'b0;

        if (bus.sync_in) begin
            state_d = S_ACC;
            // short window: flag it and drop the old window's in-flight beat
            if (state_q == S_ACC && bl_cnt_q != '0) begin
                err_d = 1'b1;
                kill  = 1'b1;
            end
            bl_base   = '0;
            win_base  = '0;
            len_base  = eff_len;
            bl_cnt_d  = '0;
            win_cnt_d = '0;
            len_d     = eff_len;
        end

        beat    = bus.vld && (state_d == S_ACC);
        b_first = (win_base == '0);
        b_last  = (win_base == len_base - ACC_LEN_BITS'(1));

        if (beat) begin
            if (bl_base == BL_W'(N_BL - 1)) begin
                bl_cnt_d = '0;
                if (b_last) begin
                    win_cnt_d = '0;
                    len_d     = eff_len;
                end else begin
                    win_cnt_d = win_base + ACC_LEN_BITS'(1);
                end
            end else begin
                bl_cnt_d = bl_base + BL_W'(1);
            end
            if (bl_base == '0 && b_first)
                mcnt_dump_d = bus.mcnt;
        end
    end

    // Datapath stages and RAM read.
    always_comb begin
        s1_din_d   = s1_din_q;
        s1_addr_d  = s1_addr_q;
        s1_first_d = s1_first_q;
        s1_last_d  = s1_last_q;
        s1_sof_d   = s1_sof_q;
        s1_mcnt_d  = s1_mcnt_q;
        rd_d       = rd_q;

        vld_pipe_d[1] = beat;
        vld_pipe_d[2] = vld_pipe_q[1] && s1_last_q && !kill;

        if (beat) begin
            s1_din_d   = bus.din;
            s1_addr_d  = bl_base;
            s1_first_d = b_first;
            s1_last_d  = b_last;
            s1_sof_d   = (bl_base == '0);
            s1_mcnt_d  = mcnt_dump_d;
            // forward the write in flight when it targets the same baseline
            // (only possible for a single-baseline configuration)
            rd_d = (vld_pipe_q[1] && s1_addr_q == bl_base) ? sum : mem[bl_base];
        end

        dout_d     = dout_q;
        sync_out_d = 1'b0;
        mcnt_out_d = mcnt_out_q;
        if (vld_pipe_d[2]) begin
            dout_d     = sum;
            sync_out_d = s1_sof_q;
            if (s1_sof_q)
                mcnt_out_d = s1_mcnt_q;
        end
    end

    for (genvar g = 0; g < N_COMP; g++) begin : g_lane
        xeng_vacc_lane #(
            .IN_WIDTH  (IN_WIDTH),
            .OUT_WIDTH (OUT_WIDTH)
        ) u_lane (
            .din_c (s1_din_q[g]),
            .acc_c (rd_q[g]),
            .first (s1_first_q),
            .sum_c (sum[g])
        );
    end

    // RAM is deliberately not reset: window 0 overwrites every entry.
    always_ff @(posedge clk) begin
        if (vld_pipe_q[1])
            mem[s1_addr_q] <= sum;
        rd_q <= rd_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bl_cnt_q    <= '0;
            win_cnt_q   <= '0;
            len_q       <= ACC_LEN_BITS'(1);
            err_q       <= 1'b0;
            mcnt_dump_q <= '0;
            s1_din_q    <= '0;
            s1_addr_q   <= '0;
            s1_first_q  <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_sof_q    <= 1'b0;
            s1_mcnt_q   <= '0;
            vld_pipe_q  <= '0;
            dout_q      <= '0;
            sync_out_q  <= 1'b0;
            mcnt_out_q  <= '0;
        end else begin
            state_q     <= state_d;
            bl_cnt_q    <= bl_cnt_d;
            win_cnt_q   <= win_cnt_d;
            len_q       <= len_d;
            err_q       <= err_d;
            mcnt_dump_q <= mcnt_dump_d;
            s1_din_q    <= s1_din_d;
            s1_addr_q   <= s1_addr_d;
            s1_first_q  <= s1_first_d;
            s1_last_q   <= s1_last_d;
            s1_sof_q    <= s1_sof_d;
            s1_mcnt_q   <= s1_mcnt_d;
            vld_pipe_q  <= vld_pipe_d;
            dout_q      <= dout_d;
            sync_out_q  <= sync_out_d;
            mcnt_out_q  <= mcnt_out_d;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.vld_out  = vld_pipe_q[STAGES];
    assign bus.sync_out = sync_out_q;
    assign bus.mcnt_out = mcnt_out_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_xeng_vacc.sv
// ---------------------------------------------------------------------------
// tb_xeng_vacc -- scoreboard bench for xeng_vacc.
// Stimulus pushes hand-computed expected beats (value, sync_out, mcnt_out,
// arrival cycle) into a queue; independent monitors pop and compare every
// vld_out beat. A second instance with OUT_WIDTH = IN_WIDTH = 18 covers wrap.
// ---------------------------------------------------------------------------
module tb_xeng_vacc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   out_seen = 0;
    int   base;

    typedef struct {
        logic [255:0] dout;
        logic         sync;
        logic [47:0]  mcnt;
        int           cyc;
    } exp_t;

    exp_t q_m[$];
    exp_t q_w[$];

    xeng_vacc_if #(.IN_WIDTH(18), .OUT_WIDTH(32), .ACC_LEN_BITS(16), .MCNT_WIDTH(48)) bus ();
    xeng_vacc_if #(.IN_WIDTH(18), .OUT_WIDTH(18), .ACC_LEN_BITS(16), .MCNT_WIDTH(48)) bus_w ();

    xeng_vacc #(.N_ANTS(8), .IN_WIDTH(18), .OUT_WIDTH(32), .ACC_LEN_BITS(16), .MCNT_WIDTH(48)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    xeng_vacc #(.N_ANTS(8), .IN_WIDTH(18), .OUT_WIDTH(18), .ACC_LEN_BITS(16), .MCNT_WIDTH(48)) u_dut_w (
        .clk (clk),
        .rst (rst),
        .bus (bus_w)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Drive nb beats of one window (all components = c). When out is set,
    // each beat is expected back 2 cycles later with value ev.
    task automatic win(input logic [17:0] c, input logic [47:0] m, input bit s,
                       input bit out, input logic [31:0] ev, input logic [47:0] em,
                       input bit sof, input bit gap, input int nb);
        exp_t e;
        for (int i = 0; i < nb; i++) begin
            bus.sync_in = s && (i == 0);
            bus.vld     = 1'b1;
            bus.din     = {8{c}};
            bus.mcnt    = m;
            if (out) begin
                e.dout = {8{ev}};
                e.sync = sof && (i == 0);
                e.mcnt = em;
                e.cyc  = cyc + 2;
                q_m.push_back(e);
            end
            @(negedge clk);
            bus.sync_in = 1'b0;
            if (gap) begin
                bus.vld = 1'b0;
                @(negedge clk);
            end
        end
        bus.vld = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.vld_out) begin
            out_seen++;
            checks++;
            if (q_m.size() == 0) begin
                errors++;
                $display("FAIL main_unexpected_beat cyc=%0d actual dout=%0h required no beat", cyc, bus.dout);
            end else begin
                e = q_m.pop_front();
                if (bus.dout !== e.dout || bus.sync_out !== e.sync || bus.mcnt_out !== e.mcnt || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL main_beat actual dout=%0h sync=%0b mcnt=%0d cyc=%0d required dout=%0h sync=%0b mcnt=%0d cyc=%0d",
                             bus.dout, bus.sync_out, bus.mcnt_out, cyc, e.dout, e.sync, e.mcnt, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus_w.vld_out) begin
            checks++;
            if (q_w.size() == 0) begin
                errors++;
                $display("FAIL wrap_unexpected_beat cyc=%0d actual dout=%0h required no beat", cyc, bus_w.dout);
            end else begin
                e = q_w.pop_front();
                if (256'(bus_w.dout) !== e.dout || bus_w.sync_out !== e.sync || bus_w.mcnt_out !== e.mcnt || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL wrap_beat actual dout=%0h sync=%0b cyc=%0d required dout=%0h sync=%0b cyc=%0d",
                             bus_w.dout, bus_w.sync_out, cyc, e.dout, e.sync, e.cyc);
                end
            end
        end
    end

    initial begin
        exp_t e;
        bus.sync_in = 1'b0; bus.vld = 1'b0; bus.din = '0; bus.mcnt = '0; bus.acc_len = 16'd1;
        bus_w.sync_in = 1'b0; bus_w.vld = 1'b0; bus_w.din = '0; bus_w.mcnt = '0; bus_w.acc_len = 16'd1;
        repeat (3) @(negedge clk);
        chk("rst_vld_out", 64'(bus.vld_out), 64'd0);
        chk("rst_sync_out", 64'(bus.sync_out), 64'd0);
        chk("rst_dout_nonzero", 64'(|bus.dout), 64'd0);
        chk("rst_mcnt_out", 64'(bus.mcnt_out), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // vld without any sync: nothing may come out
        base = out_seen;
        bus.vld = 1'b1;
        bus.din = {8{18'h00123}};
        repeat (100) @(negedge clk);
        bus.vld = 1'b0;
        repeat (4) @(negedge clk);
        chk("nosync_out_beats", 64'(out_seen - base), 64'd0);
        chk("nosync_err", 64'(bus.err), 64'd0);

        // acc_len=1, all components -3
        bus.acc_len = 16'd1;
        win(18'h3FFFD, 48'd5, 1'b1, 1'b1, 32'hFFFFFFFD, 48'd5, 1'b1, 1'b0, 36);

        // acc_len=4, 81 per component, two back-to-back dumps
        bus.acc_len = 16'd4;
        for (int w = 0; w < 8; w++)
            win(18'd81, 48'(100 + w), w == 0, (w % 4) == 3, 32'd324,
                (w < 4) ? 48'd100 : 48'd104, 1'b1, 1'b0, 36);

        // acc_len=0 acts as 1; a change mid-dump only lands at the dump end
        bus.acc_len = 16'd0;
        win(18'd1000, 48'd200, 1'b1, 1'b1, 32'd1000, 48'd200, 1'b1, 1'b0, 1);
        bus.acc_len = 16'd3;
        win(18'd1000, 48'd200, 1'b0, 1'b1, 32'd1000, 48'd200, 1'b0, 1'b0, 35);
        for (int w = 0; w < 3; w++)
            win(18'd2, 48'(300 + w), 1'b0, w == 2, 32'd6, 48'd300, 1'b1, 1'b0, 36);

        // acc_len=2 with vld toggling every cycle
        bus.acc_len = 16'd2;
        for (int w = 0; w < 2; w++)
            win(18'd7, 48'(400 + w), w == 0, w == 1, 32'd14, 48'd400, 1'b1, 1'b1, 36);
        repeat (4) @(negedge clk);
        chk("err_before_short", 64'(bus.err), 64'd0);

        // short window (10 beats) then a full dump
        win(18'd1, 48'd500, 1'b1, 1'b0, 32'd0, 48'd0, 1'b0, 1'b0, 10);
        for (int w = 0; w < 2; w++)
            win(18'h3FFFB, 48'(510 + w), w == 0, w == 1, 32'hFFFFFFF6, 48'd510, 1'b1, 1'b0, 36);
        chk("err_sticky_after_dump", 64'(bus.err), 64'd1);
        repeat (4) @(negedge clk);
        chk("err_sticky_later", 64'(bus.err), 64'd1);

        // reset in the middle of a dump
        bus.acc_len = 16'd3;
        win(18'd1, 48'd600, 1'b1, 1'b0, 32'd0, 48'd0, 1'b0, 1'b0, 36);
        win(18'd1, 48'd601, 1'b0, 1'b0, 32'd0, 48'd0, 1'b0, 1'b0, 4);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_vld_out", 64'(bus.vld_out), 64'd0);
        chk("rst2_dout_nonzero", 64'(|bus.dout), 64'd0);
        chk("rst2_mcnt_out", 64'(bus.mcnt_out), 64'd0);
        chk("rst2_err", 64'(bus.err), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = out_seen;
        bus.vld = 1'b1;
        repeat (50) @(negedge clk);
        bus.vld = 1'b0;
        repeat (4) @(negedge clk);
        chk("postrst_out_beats", 64'(out_seen - base), 64'd0);
        chk("postrst_err", 64'(bus.err), 64'd0);
        bus.acc_len = 16'd1;
        win(18'd9, 48'd700, 1'b1, 1'b1, 32'd9, 48'd700, 1'b1, 1'b0, 36);

        // 18-bit accumulator: 131071 + 131071 wraps to -2
        bus_w.acc_len = 16'd2;
        for (int i = 0; i < 72; i++) begin
            bus_w.sync_in = (i == 0);
            bus_w.vld     = 1'b1;
            bus_w.din     = {8{18'h1FFFF}};
            bus_w.mcnt    = 48'd800;
            if (i >= 36) begin
                e.dout = 256'({8{18'h3FFFE}});
                e.sync = (i == 36);
                e.mcnt = 48'd800;
                e.cyc  = cyc + 2;
                q_w.push_back(e);
            end
            @(negedge clk);
            bus_w.sync_in = 1'b0;
        end
        bus_w.vld = 1'b0;

        repeat (6) @(negedge clk);
        chk("main_queue_drained", 64'(q_m.size()), 64'd0);
        chk("wrap_queue_drained", 64'(q_w.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
